// File: rtl/cpu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Holds the LSU state encoding, RV32I funct3 access codes and access-size decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StWaitRvalid,
    StDone
  } lsu_state_t;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings (011/110/111) fall through to word accesses.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SzByte;
      F3_H, F3_HU: sz = SzHalf;
      F3_W:        sz = SzWord;
      default:     sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic mis;
    case (f3_size(f3))
      SzByte:  mis = 1'b0;
      SzHalf:  mis = offset[0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the LSU: req/gnt request phase, rvalid/rdata response phase.
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/replication and load extract/extend.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;
  logic        ld_signed;

  always_comb begin
    st_be_o    = 4'hF;
    st_wdata_o = st_data_i;
    case (f3_size(st_funct3_i))
      SzByte: begin
        st_be_o    = 4'b0001 << st_offset_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SzHalf: begin
        st_be_o    = 4'b0011 << {st_offset_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword loads are aligned, so a byte-granular shift also selects the right half.
  assign ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};
  assign ld_signed  = ~ld_funct3_i[2];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (f3_size(ld_funct3_i))
      SzByte:  ld_data_o = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SzHalf:  ld_data_o = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues req/gnt/rvalid transactions, stalls the pipeline while
// one is in flight, formats load data and flags misaligned accesses and bus timeouts.
module mem_stage_lsu
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              memreadM_i,
  input  logic              memwriteM_i,
  input  logic [2:0]        funct3M_i,
  input  logic [ADDR_W-1:0] aluresultM_i,
  input  logic [DATA_W-1:0] writedataM_i,
  output logic [DATA_W-1:0] readdataM_o,
  output logic              stallM_o,
  output logic              misaligned_o,
  output logic              buserr_o,
  mem_stage_lsu_if.master   dmem
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic              active_q;
  logic [15:0]       cnt_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              access, mis_access, issue, in_wait, timeout;
  logic [3:0]        st_be, be_now;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [ADDR_W-1:0] addr_now;

  assign access     = memreadM_i | memwriteM_i;
  assign mis_access = is_misaligned(funct3M_i, aluresultM_i[1:0]);
  // active_q keeps every output quiet on the first cycle after reset release.
  assign issue      = active_q && (state_q == StIdle) && access && !mis_access;
  assign in_wait    = (state_q == StWaitGnt) || (state_q == StWaitRvalid);
  assign timeout    = in_wait && (cnt_q == CntLast);
  assign addr_now   = {aluresultM_i[ADDR_W-1:2], 2'b00};
  assign be_now     = memwriteM_i ? st_be : 4'hF;

  lsu_align u_align (
    .st_funct3_i (funct3M_i),
    .st_offset_i (aluresultM_i[1:0]),
    .st_data_i   (writedataM_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (f3_q),
    .ld_offset_i (off_q),
    .ld_rdata_i  (rdata_q),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue) state_d = dmem.gnt ? StWaitRvalid : StWaitGnt;
      end
      StWaitGnt: begin
        if (timeout)       state_d = StDone;
        else if (dmem.gnt) state_d = StWaitRvalid;
      end
      StWaitRvalid: begin
        if (timeout || dmem.rvalid) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      active_q <= 1'b1;
      if (issue) begin
        cnt_q   <= '0;
        off_q   <= aluresultM_i[1:0];
        f3_q    <= funct3M_i;
        we_q    <= memwriteM_i;
        addr_q  <= addr_now;
        be_q    <= be_now;
        wdata_q <= st_wdata;
      end else if (in_wait) begin
        cnt_q <= cnt_q + 16'd1;
      end
      // A timeout beats a same-cycle rvalid and leaves an all-zero buffer.
      if (timeout) begin
        rdata_q <= '0;
      end else if ((state_q == StWaitRvalid) && dmem.rvalid) begin
        rdata_q <= dmem.rdata;
      end
    end
  end

  always_comb begin
    dmem.req     = 1'b0;
    dmem.we      = 1'b0;
    dmem.be      = '0;
    dmem.addr    = '0;
    dmem.wdata   = '0;
    stallM_o     = 1'b0;
    misaligned_o = 1'b0;
    buserr_o     = 1'b0;
    readdataM_o  = '0;
    if (active_q) begin
      unique case (state_q)
        StIdle: begin
          if (access && mis_access) begin
            misaligned_o = 1'b1;
          end else if (access) begin
            dmem.req   = 1'b1;
            dmem.we    = memwriteM_i;
            dmem.be    = be_now;
            dmem.addr  = addr_now;
            dmem.wdata = st_wdata;
            stallM_o   = 1'b1;
          end
        end
        StWaitGnt: begin
          dmem.req   = 1'b1;
          dmem.we    = we_q;
          dmem.be    = be_q;
          dmem.addr  = addr_q;
          dmem.wdata = wdata_q;
          stallM_o   = 1'b1;
          buserr_o   = timeout;
        end
        StWaitRvalid: begin
          stallM_o = 1'b1;
          buserr_o = timeout;
        end
        StDone: begin
          readdataM_o = we_q ? '0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a responding memory plus a byte-addressed reference model.
module tb_mem_stage_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] alures, wdata_in, readdata;
  logic        stall, mis, berr;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .memreadM_i   (memread),
    .memwriteM_i  (memwrite),
    .funct3M_i    (funct3),
    .aluresultM_i (alures),
    .writedataM_i (wdata_in),
    .readdataM_o  (readdata),
    .stallM_o     (stall),
    .misaligned_o (mis),
    .buserr_o     (berr),
    .dmem         (dmem_if)
  );

  always #5 clk = ~clk;

  bit [31:0] bus_mem [256];
  bit [7:0]  ref_mem [1024];
  int        checks = 0;
  int        errors = 0;

  int          obs_stall, obs_req, obs_mis, obs_err;
  logic        obs_stable, obs_done, obs_we;
  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3);
    int     n;
    longint v;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a[9:0]) + i]) << (8 * i);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    bus_mem[a[9:2]] = w;
    for (int i = 0; i < 4; i++) ref_mem[int'({a[9:2], 2'b00}) + i] = w[8*i +: 8];
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[int'(a[9:0]) + i] = wd[8*i +: 8];
  endtask

  // Drives one MEM-stage access from a negedge and plays the memory side until stall drops.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int gnt_wait, input int rv_wait);
    int   waited, rv_cnt;
    logic pend, granted, gave_rv;
    obs_stall = 0; obs_req = 0; obs_mis = 0; obs_err = 0;
    obs_stable = 1'b1; obs_done = 1'b0; obs_rd = '0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    memread = rd; memwrite = wr; funct3 = f3; alures = addr; wdata_in = wd;
    waited = 0; rv_cnt = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 100 && !obs_done; cyc++) begin
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = $urandom;
      granted = 1'b0; gave_rv = 1'b0;
      #1;
      if (dmem_if.req) begin
        if (obs_req == 0) begin
          obs_addr = dmem_if.addr; obs_be = dmem_if.be;
          obs_wdata = dmem_if.wdata; obs_we = dmem_if.we;
        end else if (dmem_if.addr !== obs_addr || dmem_if.be !== obs_be ||
                     dmem_if.wdata !== obs_wdata || dmem_if.we !== obs_we) begin
          obs_stable = 1'b0;
        end
        obs_req++;
        if (waited == gnt_wait) begin
          dmem_if.gnt = 1'b1; granted = 1'b1;
          if (dmem_if.we)
            for (int i = 0; i < 4; i++)
              if (dmem_if.be[i]) bus_mem[dmem_if.addr[9:2]][8*i +: 8] = dmem_if.wdata[8*i +: 8];
        end else begin
          waited++;
        end
      end else if (pend) begin
        if (rv_cnt == rv_wait) begin
          dmem_if.rvalid = 1'b1; dmem_if.rdata = bus_mem[obs_addr[9:2]]; gave_rv = 1'b1;
        end else begin
          rv_cnt++;
        end
      end
      #1;
      if (stall) obs_stall++;
      if (mis) obs_mis++;
      if (berr) obs_err++;
      if (!stall) begin
        obs_rd = readdata; obs_done = 1'b1;
      end
      @(posedge clk);
      if (granted) pend = 1'b1;
      if (gave_rv) pend = 1'b0;
      @(negedge clk);
    end
    memread = 1'b0; memwrite = 1'b0; dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    checks++;
    if (!obs_done) begin
      errors++;
      $display("FAIL txn_bound: stall still %0b after 100 cycles, required 0", stall);
    end
  endtask

  task automatic test_reset;
    memread = 1'b1; funct3 = 3'b010; alures = 32'h101;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL rst_mis: got %0b want 0", mis); end
    alures = 32'h100; #1;
    checks++;
    if ({dmem_if.req, stall, berr, readdata} !== 35'd0) begin
      errors++; $display("FAIL rst_outputs: req=%0b stall=%0b data=%h want all 0",
                         dmem_if.req, stall, readdata);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (dmem_if.req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_first_cycle: req=%0b stall=%0b want 0 0", dmem_if.req, stall);
    end
    memread = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load;
    set_word(32'h100, 32'hDEADBEEF);
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
    checks++;
    if (obs_stall !== 2) begin errors++; $display("FAIL lw_stall: got %0d want 2", obs_stall); end
    checks++;
    if (obs_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", obs_rd); end
    checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      errors++; $display("FAIL lw_bus: addr=%h be=%h we=%0b want 100 f 0", obs_addr, obs_be, obs_we);
    end
  endtask

  task automatic test_sign_extend;
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    logic [31:0] exps [4];
    f3s  = '{3'd0, 3'd4, 3'd1, 3'd5};
    ads  = '{32'h103, 32'h103, 32'h102, 32'h102};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    set_word(32'h100, 32'h80FF0000);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0, f3s[i], ads[i], 32'h0, 0, 0);
      checks++;
      if (obs_rd !== exps[i]) begin
        errors++; $display("FAIL ext_%0d: got %h want %h", i, obs_rd, exps[i]);
      end
    end
  endtask

  task automatic test_store_lanes;
    run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0);
    ref_store(32'h202, 3'b001, 32'h1234ABCD);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h200 || obs_we !== 1'b1) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h addr=%h we=%0b want 1100 abcdabcd 200 1",
                         obs_be, obs_wdata, obs_addr, obs_we);
    end
    checks++;
    if (obs_rd !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h want 0", obs_rd); end
    run_txn(1'b0, 1'b1, 3'b000, 32'h201, 32'h00000077, 1, 1);
    ref_store(32'h201, 3'b000, 32'h00000077);
    checks++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'h77777777) begin
      errors++; $display("FAIL sb_bus: be=%b wdata=%h want 0010 77777777", obs_be, obs_wdata);
    end
    run_txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 0);
    checks++;
    if (obs_rd !== exp_load(32'h200, 3'b010)) begin
      errors++; $display("FAIL st_readback: got %h want %h", obs_rd, exp_load(32'h200, 3'b010));
    end
  endtask

  task automatic test_misaligned;
    run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0);
    checks++;
    if (obs_mis !== 1 || obs_req !== 0 || obs_stall !== 0 || obs_rd !== 32'h0) begin
      errors++; $display("FAIL lw_misaligned: mis=%0d req=%0d stall=%0d data=%h want 1 0 0 0",
                         obs_mis, obs_req, obs_stall, obs_rd);
    end
    run_txn(1'b0, 1'b1, 3'b001, 32'h10B, 32'h5555, 0, 0);
    checks++;
    if (obs_mis !== 1 || obs_req !== 0) begin
      errors++; $display("FAIL sh_misaligned: mis=%0d req=%0d want 1 0", obs_mis, obs_req);
    end
  endtask

  task automatic test_gnt_stall;
    set_word(32'h104, 32'hCAFE1234);
    run_txn(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 3, 0);
    checks++;
    if (obs_req !== 4 || obs_stable !== 1'b1) begin
      errors++; $display("FAIL gnt_hold: req_cycles=%0d stable=%0b want 4 1", obs_req, obs_stable);
    end
    checks++;
    if (obs_stall !== 5 || obs_rd !== 32'hCAFE1234) begin
      errors++; $display("FAIL gnt_done: stall=%0d data=%h want 5 cafe1234", obs_stall, obs_rd);
    end
  endtask

  task automatic test_timeout;
    int gws [3];
    int rws [3];
    int reqs [3];
    gws = '{1000, 0, 0}; rws = '{0, 1000, 7}; reqs = '{9, 1, 1};
    set_word(32'h10C, 32'h5A5A5A5A);
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, gws[i], rws[i]);
      checks++;
      if (obs_err !== 1 || obs_rd !== 32'h0) begin
        errors++; $display("FAIL timeout_%0d: buserr=%0d data=%h want 1 0", i, obs_err, obs_rd);
      end
      checks++;
      if (obs_stall !== 1 + TO || obs_req !== reqs[i]) begin
        errors++; $display("FAIL timeout_len_%0d: stall=%0d req=%0d want %0d %0d",
                           i, obs_stall, obs_req, 1 + TO, reqs[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    memread = 1'b1; funct3 = 3'b010; alures = 32'h100; #1;
    dmem_if.gnt = dmem_if.req;
    @(posedge clk); @(negedge clk);
    dmem_if.gnt = 1'b0;
    rst_n = 1'b0; #1;
    checks++;
    if ({dmem_if.req, stall, mis, berr, readdata} !== 36'd0) begin
      errors++; $display("FAIL rst_inflight: req=%0b stall=%0b data=%h want all 0",
                         dmem_if.req, stall, readdata);
    end
    memread = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_word(32'h104, 32'h0BADF00D);
    run_txn(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 0);
    checks++;
    if (obs_stall !== 2 || obs_rd !== 32'h0BADF00D) begin
      errors++; $display("FAIL post_rst_lw: stall=%0d data=%h want 2 0badf00d", obs_stall, obs_rd);
    end
  endtask

  task automatic test_back_to_back;
    logic        is_st, bad;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          n, off, gw, rw;
    for (int t = 0; t < 80; t++) begin
      is_st = 1'($urandom_range(0, 1));
      f3    = is_st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      n     = size_of(f3);
      off   = $urandom_range(0, 3);
      if ($urandom_range(0, 7) != 0) off = off - (off % n);
      bad   = (off % n) != 0;
      addr  = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'(off);
      wd    = $urandom;
      gw    = $urandom_range(0, 3);
      rw    = $urandom_range(0, 2);
      exp_rd = (is_st || bad) ? 32'h0 : exp_load(addr, f3);
      exp_be = is_st ? 4'(((1 << n) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
      run_txn(!is_st, is_st, f3, addr, wd, gw, rw);
      if (is_st && !bad) ref_store(addr, f3, wd);
      checks++;
      if (obs_mis !== int'(bad) || obs_err !== 0) begin
        errors++; $display("FAIL rnd_flags[%0d]: mis=%0d err=%0d want %0d 0", t, obs_mis, obs_err, bad);
      end
      checks++;
      if (obs_stall !== (bad ? 0 : gw + rw + 2) || obs_req !== (bad ? 0 : gw + 1)) begin
        errors++; $display("FAIL rnd_timing[%0d]: stall=%0d req=%0d want %0d %0d", t,
                           obs_stall, obs_req, bad ? 0 : gw + rw + 2, bad ? 0 : gw + 1);
      end
      checks++;
      if (obs_rd !== exp_rd) begin
        errors++; $display("FAIL rnd_rdata[%0d]: f3=%0d addr=%h got %h want %h", t, f3, addr, obs_rd, exp_rd);
      end
      if (!bad) begin
        checks++;
        if (obs_be !== exp_be || obs_we !== is_st || obs_addr !== {addr[31:2], 2'b00} ||
            obs_stable !== 1'b1 || (is_st && obs_wdata !== exp_wd)) begin
          errors++; $display("FAIL rnd_bus[%0d]: be=%b we=%0b addr=%h wdata=%h want %b %0b %h %h",
                             t, obs_be, obs_we, obs_addr, obs_wdata, exp_be, is_st,
                             {addr[31:2], 2'b00}, exp_wd);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    memread = 1'b0; memwrite = 1'b0; funct3 = '0; alures = '0; wdata_in = '0;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0;
    for (int w = 0; w < 256; w++) set_word(32'(w * 4), $urandom);
    test_reset();
    test_basic_load();
    test_sign_extend();
    test_store_lanes();
    test_misaligned();
    test_gnt_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
